// File: rtl/add_arbiter_if.sv
// Handshake bundle for add_arbiter: N request channels sharing one adder, one response channel.
// "slave" is the arbiter's view; "master" is the requester/consumer side.
interface add_arbiter_if #(
    parameter int W = 8,
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_in0;
    logic [N*W-1:0] req_in1;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_sum;
    logic           resp_carry;
    logic [IW-1:0]  resp_id;

    modport master (
        output req_valid, req_in0, req_in1, resp_ready,
        input  req_ready, resp_valid, resp_sum, resp_carry, resp_id
    );

    modport slave (
        input  req_valid, req_in0, req_in1, resp_ready,
        output req_ready, resp_valid, resp_sum, resp_carry, resp_id
    );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one W-bit adder among N requesters; one operation in flight,
// result held until the consumer takes it.
module add_arbiter #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    add_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] id_q;
    logic [W-1:0]  op0_q, op1_q;

    logic          grant_found;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] scan_idx;
    logic [N-1:0]  grant_onehot;
    logic [W-1:0]  sel_in0, sel_in1;
    logic          accept;

    // Round-robin search starting at ptr, wrapping explicitly so non-power-of-two N works.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = ptr_q;
        for (int k = 0; k < N; k++) begin
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
            scan_idx = (scan_idx == IW'(N - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    always_comb begin
        sel_in0 = '0;
        sel_in1 = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_in0 = bus.req_in0[i*W +: W];
                sel_in1 = bus.req_in1[i*W +: W];
            end
        end
    end

    // Gated by reset_n so no grant is visible while reset is held, independent of the clock.
    always_comb begin
        grant_onehot            = '0;
        grant_onehot[grant_idx] = grant_found && (state_q == IDLE) && reset_n;
    end

    assign bus.req_ready = grant_onehot;
    assign accept        = |grant_onehot;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            // NOTE: operand registers are reset so the held sum/carry read zero during reset.
            op0_q   <= '0;
            op1_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
                id_q  <= grant_idx;
                op0_q <= sel_in0;
                op1_q <= sel_in1;
            end
        end
    end

    assign bus.resp_valid                 = (state_q == RESP);
    assign {bus.resp_carry, bus.resp_sum} = {1'b0, op0_q} + {1'b0, op1_q};
    assign bus.resp_id                    = id_q;
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter W, default 8: operand and sum width in bits, W >= 1.
REQ-002 Parameter N, default 4: number of requesters, N >= 2; IW = clog2(N).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  N  bit i: requester i presents an operand pair.
REQ-006 req_ready  output  N  bit i: requester i's pair is accepted this cycle.
REQ-007 req_in0  input  N*W  operand 0; requester i occupies bits [i*W +: W].
REQ-008 req_in1  input  N*W  operand 1; same packing as req_in0.
REQ-009 resp_valid  output  1  result is held on resp_sum, resp_carry and resp_id.
REQ-010 resp_ready  input  1  consumer takes the result this cycle.
REQ-011 resp_sum  output  W  (in0 + in1) mod 2^W.
REQ-012 resp_carry  output  1  carry-out of the W-bit addition.
REQ-013 resp_id  output  IW  index of the requester that owns the result.

Function
REQ-014 The block shall share one W-bit adder among N requesters, with at most one operation in flight.
REQ-015 FSM states:
  - IDLE: no result held.
  - RESP: result held.
REQ-016 In IDLE, req_ready shall be one-hot on the round-robin winner among the set bits of req_valid, and all-zero when req_valid is zero.
REQ-017 In RESP, req_ready shall be all-zero.
REQ-018 req_ready shall depend combinationally on req_valid and registered state only, never on resp_ready.
REQ-019 Round-robin rule: the search starts at index ptr and increments mod N; the first i with req_valid[i]=1 wins.
REQ-020 On acceptance (req_valid[i] & req_ready[i]), ptr shall update to (i+1) mod N; otherwise ptr holds.
REQ-021 On acceptance, the operands of requester i shall be registered at that clock edge, the FSM shall enter RESP, and resp_id shall be set to i.
REQ-022 resp_valid shall be 1 exactly while the FSM is in RESP, so a result appears on the cycle after acceptance (latency 1).
REQ-023 resp_sum and resp_carry shall be the W+1-bit sum of the registered operands: {resp_carry, resp_sum} = in0 + in1.
REQ-024 resp_sum, resp_carry and resp_id shall hold stable while resp_valid=1 and resp_ready=0.
REQ-025 When resp_valid & resp_ready, the FSM shall return to IDLE; no acceptance occurs in that same cycle, giving a peak throughput of one result per 2 cycles.
REQ-026 Requesters may drop req_valid before acceptance without protocol error; a dropped request shall never be accepted.
REQ-027 resp_ready asserted while the FSM is in IDLE shall have no effect.
REQ-028 Operand values shall be sampled only at the acceptance edge; later changes on req_in0 and req_in1 shall not affect the held result.

Reset
REQ-029 While reset_n=0, regardless of clock:
  - FSM = IDLE, ptr = 0.
  - resp_valid = 0, resp_sum = 0, resp_carry = 0, resp_id = 0.
  - req_ready = 0.
REQ-030 A reset asserted in RESP shall discard the held result; no response for that request shall be produced after reset.
REQ-031 The first clock edge after reset_n rises may accept a request, using ptr = 0.

Verification
REQ-032 The bench shall cover the following scenarios (W=8, N=4):
  - Single requester: req_valid=0100, in0[2]=0x12, in1[2]=0x34 -> req_ready=0100 in cycle t; in t+1 resp_valid=1, resp_sum=0x46, resp_carry=0, resp_id=2.
  - Overflow: in0=0xFF, in1=0x01 -> resp_sum=0x00, resp_carry=1; in0=0x80, in1=0x80 -> resp_sum=0x00, resp_carry=1.
  - Fairness: req_valid=1111 held, resp_ready=1 -> grants in order 0,1,2,3,0, one every 2 cycles, with resp_id matching.
  - Backpressure: resp_ready=0 for 5 cycles after a result -> resp_valid, resp_sum and resp_id stable and req_ready=0000 throughout; after resp_ready=1, the next grant comes 1 cycle later.
  - Skip: ptr=1, req_valid=1001 -> winner is 3, then ptr=0; the next grant with req_valid=1001 goes to 0.
  - Reset mid-operation: reset_n=0 during RESP with id=1 -> resp_valid=0 immediately; after release, req_valid=0010 is accepted with ptr=0 semantics and no stale result is produced.
